// File: rtl/button_repeat.sv
// Turns a debounced button level into press/auto-repeat pulses, a release pulse
// and a held level. One 24-bit counter times both the initial delay and the repeat period.
module button_repeat #(
   parameter int unsigned DELAY_CYCLES  = 6000000,
   parameter int unsigned REPEAT_CYCLES = 1200000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_level,
   output logic o_press,
   output logic o_release,
   output logic o_held
);

   localparam int unsigned CNT_W = 24;
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;
   logic             r_release;
   logic             r_held;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_press_nxt;
   logic             w_release_nxt;
   logic             w_held_nxt;

   // State, counter and output registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_held    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_held    <= w_held_nxt;
      end
   end

   // Next state and next outputs; a low level always wins over counter expiry
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_held_nxt    = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (i_level) begin
               w_state_nxt = DELAY;
               w_press_nxt = 1'b1;
               w_held_nxt  = 1'b1;
            end
         end
         DELAY: begin
            if (!i_level) begin
               w_state_nxt   = IDLE;
               w_cnt_nxt     = '0;
               w_release_nxt = 1'b1;
            end else if (r_cnt == DELAY_LAST) begin
               w_state_nxt = REPEAT;
               w_cnt_nxt   = '0;
               w_press_nxt = 1'b1;
               w_held_nxt  = 1'b1;
            end else begin
               w_cnt_nxt  = r_cnt + CNT_W'(1);
               w_held_nxt = 1'b1;
            end
         end
         REPEAT: begin
            if (!i_level) begin
               w_state_nxt   = IDLE;
               w_cnt_nxt     = '0;
               w_release_nxt = 1'b1;
            end else if (r_cnt == REPEAT_LAST) begin
               w_cnt_nxt   = '0;
               w_press_nxt = 1'b1;
               w_held_nxt  = 1'b1;
            end else begin
               w_cnt_nxt  = r_cnt + CNT_W'(1);
               w_held_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_held    = r_held;

endmodule

// File: tb/tb_button_repeat.sv
// Directed and randomized bench for button_repeat; expectations come from a
// hold-length model: pulses follow from how many consecutive edges the level has been 1.
module tb_button_repeat;

   localparam int DLY = 5;
   localparam int RPT = 3;

   logic clk = 1'b0;
   logic rst;
   logic lvl;
   logic o_press;
   logic o_release;
   logic o_held;

   int tests   = 0;
   int fails   = 0;
   int hold_k  = 0;
   int n_press = 0;
   int n_rel   = 0;

   button_repeat #(
      .DELAY_CYCLES (DLY),
      .REPEAT_CYCLES(RPT)
   ) dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_level  (lvl),
      .o_press  (o_press),
      .o_release(o_release),
      .o_held   (o_held)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge: drive inputs, advance the model, compare all outputs after the edge
   task automatic step(input logic r, input logic l);
      logic ep;
      logic er;
      logic eh;
      rst = r;
      lvl = l;
      @(posedge clk);
      #1;
      ep = 1'b0;
      er = 1'b0;
      eh = 1'b0;
      if (r) begin
         hold_k = 0;
      end else if (l) begin
         hold_k++;
         eh = 1'b1;
         ep = (hold_k == 1) ||
              ((hold_k - 1 >= DLY) && (((hold_k - 1 - DLY) % RPT) == 0));
      end else begin
         er     = (hold_k > 0);
         hold_k = 0;
      end
      check_bit("press", o_press, ep);
      check_bit("release", o_release, er);
      check_bit("held", o_held, eh);
      if (o_press) n_press++;
      if (o_release) n_rel++;
   endtask

   initial begin
      int hold_len;
      int gap_len;
      rst = 1'b1;
      lvl = 1'b0;

      // Reset with button up
      repeat (4) step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);

      // Long hold: one press plus six repeats, then one release
      n_press = 0;
      n_rel   = 0;
      repeat (21) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_int("long_hold_presses", n_press, 7);
      check_int("long_hold_releases", n_rel, 1);
      repeat (3) step(1'b0, 1'b0);

      // Short tap
      n_press = 0;
      repeat (3) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_int("short_tap_presses", n_press, 1);
      repeat (2) step(1'b0, 1'b0);

      // Release on the delay-expiry edge
      n_press = 0;
      repeat (5) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_int("expiry_release_presses", n_press, 1);
      repeat (2) step(1'b0, 1'b0);

      // Reset mid-delay with button held, then resume timing
      repeat (3) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (12) step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Reset mid-repeat
      repeat (10) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Rapid retap
      n_press = 0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_int("retap_presses", n_press, 2);

      // Randomized holds and gaps with occasional reset
      for (int i = 0; i < 150; i++) begin
         hold_len = int'($urandom_range(1, 25));
         gap_len  = int'($urandom_range(1, 4));
         for (int j = 0; j < hold_len; j++)
            step($urandom_range(0, 60) == 0, 1'b1);
         for (int j = 0; j < gap_len; j++)
            step($urandom_range(0, 60) == 0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
